// File: rtl/dht11_pkg.sv
// Shared DHT11 definitions: FSM encoding, default bus timing and frame helpers.
package dht11_pkg;

  localparam int unsigned FRAME_BITS       = 40;
  localparam int unsigned US_W             = 15;
  localparam int unsigned US_MAX           = 32767;

  localparam int unsigned DEF_CLK_PER_US   = 1;
  localparam int unsigned DEF_START_MIN_US = 18000;
  localparam int unsigned DEF_RESP_WAIT_US = 30;
  localparam int unsigned DEF_ACK_US       = 80;
  localparam int unsigned DEF_BIT_LOW_US   = 50;
  localparam int unsigned DEF_ZERO_HIGH_US = 26;
  localparam int unsigned DEF_ONE_HIGH_US  = 70;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_LOW,
    ST_RESP_DLY,
    ST_ACK_LOW,
    ST_ACK_HIGH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_END_LOW
  } dht_state_e;

  // Mod-256 sum of the four payload bytes.
  function automatic logic [7:0] dht_checksum(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c, input logic [7:0] d);
    logic [7:0] s;
    s = a + b + c + d;
    return s;
  endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// Microsecond timebase: one-cycle us_tick every CLK_PER_US clocks.
module dht11_us_tick #(
  parameter int unsigned CLK_PER_US = 1
) (
  input  logic clk,
  input  logic nRST,
  output logic us_tick
);

  localparam int unsigned CW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Prescaler wrap and tick generation.
  always_comb begin
    tick_d = (cnt_q == CW'(CLK_PER_US - 1));
    cnt_d  = tick_d ? '0 : cnt_q + CW'(1);
  end

  // Prescaler registers.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign us_tick = tick_q;

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor-side emulator: measures the host start low, then drives the
// response and the 40-bit frame open-drain style through dq_oe.
module dht11_responder
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_PER_US   = DEF_CLK_PER_US,
  parameter int unsigned START_MIN_US = DEF_START_MIN_US,
  parameter int unsigned RESP_WAIT_US = DEF_RESP_WAIT_US,
  parameter int unsigned ACK_US       = DEF_ACK_US,
  parameter int unsigned BIT_LOW_US   = DEF_BIT_LOW_US,
  parameter int unsigned ZERO_HIGH_US = DEF_ZERO_HIGH_US,
  parameter int unsigned ONE_HIGH_US  = DEF_ONE_HIGH_US
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       dq_in,
  output logic       dq_oe,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] tmp_int,
  input  logic [7:0] tmp_dec,
  output logic       busy,
  output logic       frame_done,
  output logic       start_err
);

  dht_state_e            state_q, state_d;
  logic [US_W-1:0]       us_q, us_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [5:0]            bit_cnt_q, bit_cnt_d;
  logic [1:0]            sync_q, sync_d;
  logic [1:0]            oe_pipe_q, oe_pipe_d;
  logic                  dq_oe_q, dq_oe_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  start_err_q, start_err_d;
  logic                  us_tick;
  logic                  host_low;
  logic                  dur_done;
  logic [US_W-1:0]       dur;

  dht11_us_tick #(.CLK_PER_US(CLK_PER_US)) u_tick (
    .clk     (clk),
    .nRST    (nRST),
    .us_tick (us_tick)
  );

  // The synced level lags our own drive by two cycles; oe_pipe masks that echo
  // so the end-low of our own frame is not mistaken for a new host start.
  assign host_low = !sync_q[1] && !oe_pipe_q[1];

  // Next-state, timing and datapath.
  always_comb begin
    state_d      = state_q;
    us_d         = us_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    start_err_d  = 1'b0;
    frame_done_d = 1'b0;
    sync_d       = {sync_q[0], dq_in};
    oe_pipe_d    = {oe_pipe_q[0], dq_oe_q};
    dur          = US_W'(1);

    case (state_q)
      ST_RESP_DLY: dur = US_W'(RESP_WAIT_US);
      ST_ACK_LOW,
      ST_ACK_HIGH: dur = US_W'(ACK_US);
      ST_BIT_LOW,
      ST_END_LOW:  dur = US_W'(BIT_LOW_US);
      ST_BIT_HIGH: dur = sr_q[FRAME_BITS-1] ? US_W'(ONE_HIGH_US) : US_W'(ZERO_HIGH_US);
      default:     dur = US_W'(1);
    endcase
    dur_done = us_tick && (us_q == dur - US_W'(1));

    if (us_tick && (us_q != US_W'(US_MAX))) us_d = us_q + US_W'(1);

    case (state_q)
      ST_IDLE: begin
        us_d = '0;
        if (host_low) state_d = ST_START_LOW;
      end
      ST_START_LOW: begin
        if (sync_q[1]) begin
          us_d = '0;
          if (us_q >= US_W'(START_MIN_US)) begin
            sr_d      = {hum_int, hum_dec, tmp_int, tmp_dec,
                         dht_checksum(hum_int, hum_dec, tmp_int, tmp_dec)};
            bit_cnt_d = '0;
            state_d   = ST_RESP_DLY;
          end else begin
            start_err_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_RESP_DLY: if (dur_done) begin us_d = '0; state_d = ST_ACK_LOW;  end
      ST_ACK_LOW:  if (dur_done) begin us_d = '0; state_d = ST_ACK_HIGH; end
      ST_ACK_HIGH: if (dur_done) begin us_d = '0; state_d = ST_BIT_LOW;  end
      ST_BIT_LOW:  if (dur_done) begin us_d = '0; state_d = ST_BIT_HIGH; end
      ST_BIT_HIGH: begin
        if (dur_done) begin
          us_d      = '0;
          sr_d      = sr_q << 1;
          bit_cnt_d = bit_cnt_q + 6'd1;
          state_d   = (bit_cnt_q == 6'(FRAME_BITS - 1)) ? ST_END_LOW : ST_BIT_LOW;
        end
      end
      ST_END_LOW: begin
        if (dur_done) begin
          us_d         = '0;
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    dq_oe_d = (state_d == ST_ACK_LOW) || (state_d == ST_BIT_LOW) || (state_d == ST_END_LOW);
    busy_d  = (state_d != ST_IDLE) && (state_d != ST_START_LOW);
  end

  // State and datapath registers; reset releases the bus immediately.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q      <= ST_IDLE;
      us_q         <= '0;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      sync_q       <= 2'b11;
      oe_pipe_q    <= 2'b00;
      dq_oe_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      start_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      us_q         <= us_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      sync_q       <= sync_d;
      oe_pipe_q    <= oe_pipe_d;
      dq_oe_q      <= dq_oe_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      start_err_q  <= start_err_d;
    end
  end

  assign dq_oe      = dq_oe_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign start_err  = start_err_q;

endmodule

// File: tb/tb_dht11_responder.sv
// Self-checking bench: host model with pull-up, frame decoded from dq_oe pulse widths.
`timescale 1ns/1ps
module tb_dht11_responder;

  // Start threshold scaled down so several frames fit a short run.
  localparam int T_MIN  = 1800;
  localparam int T_HOST = 1900;
  localparam int T_RESP = 30;
  localparam int T_ACK  = 80;
  localparam int T_BL   = 50;
  localparam int T_ZERO = 26;
  localparam int T_ONE  = 70;

  logic       clk = 1'b0;
  logic       nRST;
  logic       host_low;
  logic       dq_in;
  logic [7:0] hi, hd, ti, td;
  wire        dq_oe, busy, frame_done, start_err;

  int errs = 0, checks = 0;
  int fd_cnt = 0, se_cnt = 0, oe_rise = 0, busy_cyc = 0;
  logic oe_prev = 1'b0;

  assign dq_in = !(dq_oe || host_low);

  always #5 clk = ~clk;

  dht11_responder #(
    .CLK_PER_US(1), .START_MIN_US(T_MIN), .RESP_WAIT_US(T_RESP), .ACK_US(T_ACK),
    .BIT_LOW_US(T_BL), .ZERO_HIGH_US(T_ZERO), .ONE_HIGH_US(T_ONE)
  ) dut (
    .clk(clk), .nRST(nRST), .dq_in(dq_in), .dq_oe(dq_oe),
    .hum_int(hi), .hum_dec(hd), .tmp_int(ti), .tmp_dec(td),
    .busy(busy), .frame_done(frame_done), .start_err(start_err)
  );

  // Event counters sampled away from the active edge.
  always @(negedge clk) begin
    oe_prev <= dq_oe;
    if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    if (start_err === 1'b1) se_cnt <= se_cnt + 1;
    if (busy === 1'b1) busy_cyc <= busy_cyc + 1;
    if (dq_oe === 1'b1 && oe_prev !== 1'b1) oe_rise <= oe_rise + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference frame: bytes in port order, then their sum mod 256.
  function automatic logic [39:0] model_frame(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c, input logic [7:0] d);
    int s;
    s = int'(a) + int'(b) + int'(c) + int'(d);
    return {a, b, c, d, 8'(s % 256)};
  endfunction

  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (dq_oe === lvl && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic host_start(input int low);
    @(negedge clk);
    host_low = 1'b1;
    repeat (low) @(negedge clk);
    host_low = 1'b0;
  endtask

  task automatic set_rand();
    hi = 8'($urandom); hd = 8'($urandom); ti = 8'($urandom); td = 8'($urandom);
  endtask

  // Decode one frame; optionally change inputs or reset at a given bit index.
  task automatic capture(input string tag, input logic [39:0] exp, input int chg_bit,
                         input int rst_bit);
    int n, lo, h, eh, bad_lo, bad_hi, fd0;
    logic [39:0] got;
    got = '0; bad_lo = 0; bad_hi = 0; fd0 = fd_cnt;
    n = 0;
    while (dq_oe !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".resp_wait"}, 64'(n >= T_RESP && n <= T_RESP + 3), 64'd1);
    check({tag, ".busy"}, 64'(busy), 64'd1);
    run_len(1'b1, n);
    check({tag, ".ack_low"}, 64'(n), 64'(T_ACK));
    run_len(1'b0, n);
    check({tag, ".ack_high"}, 64'(n), 64'(T_ACK));
    for (int i = 0; i < 40; i++) begin
      if (i == chg_bit) begin
        hi = 8'hAA; hd = 8'hAA; ti = 8'hAA; td = 8'hAA;
      end
      if (i == rst_bit) begin
        #2 nRST = 1'b0;
        #1;
        check({tag, ".oe_at_reset"}, 64'(dq_oe), 64'd0);
        check({tag, ".busy_at_reset"}, 64'(busy), 64'd0);
        return;
      end
      run_len(1'b1, lo);
      if (lo != T_BL) bad_lo++;
      run_len(1'b0, h);
      eh = exp[39-i] ? T_ONE : T_ZERO;
      if (h != eh) bad_hi++;
      got[39-i] = (h > (T_ZERO + T_ONE) / 2);
    end
    check({tag, ".bit_lows_bad"}, 64'(bad_lo), 64'd0);
    check({tag, ".bit_highs_bad"}, 64'(bad_hi), 64'd0);
    check({tag, ".frame"}, 64'(got), 64'(exp));
    run_len(1'b1, n);
    check({tag, ".end_low"}, 64'(n), 64'(T_BL));
    check({tag, ".busy_after"}, 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check({tag, ".frame_done_once"}, 64'(fd_cnt - fd0), 64'd1);
  endtask

  initial begin
    int oe0, se0, b0, fd0, low;
    logic [39:0] e1;
    nRST = 1'b0; host_low = 1'b0;
    hi = 8'h00; hd = 8'h00; ti = 8'h00; td = 8'h00;
    repeat (3) @(negedge clk);
    check("rst.dq_oe", 64'(dq_oe), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.frame_done", 64'(frame_done), 64'd0);
    check("rst.start_err", 64'(start_err), 64'd0);
    nRST = 1'b1;
    repeat (20) @(negedge clk);

    // Nominal frame.
    hi = 8'h37; hd = 8'h00; ti = 8'h19; td = 8'h00;
    host_start(T_HOST);
    capture("t1", 40'h37_00_19_00_50, -1, -1);
    repeat (50) @(negedge clk);

    // Short host lows are rejected with a single error pulse and no response.
    for (int k = 0; k < 2; k++) begin
      low = (k == 0) ? 500 : int'($urandom_range(100, T_MIN - 100));
      se0 = se_cnt; oe0 = oe_rise; b0 = busy_cyc;
      host_start(low);
      repeat (200) @(negedge clk);
      check($sformatf("t2.start_err_%0d", k), 64'(se_cnt - se0), 64'd1);
      check($sformatf("t2.no_oe_%0d", k), 64'(oe_rise - oe0), 64'd0);
      check($sformatf("t2.no_busy_%0d", k), 64'(busy_cyc - b0), 64'd0);
    end

    // Checksum wraps mod 256.
    hi = 8'hFF; hd = 8'hFF; ti = 8'h02; td = 8'h01;
    host_start(T_HOST);
    capture("t3", 40'hFF_FF_02_01_01, -1, -1);
    repeat (50) @(negedge clk);

    // Inputs changed mid-frame do not affect the latched frame.
    set_rand();
    e1 = model_frame(hi, hd, ti, td);
    host_start(T_HOST);
    capture("t4", e1, 10, -1);
    repeat (50) @(negedge clk);

    // Reset mid-frame, no resume, then a fresh full frame.
    set_rand();
    e1 = model_frame(hi, hd, ti, td);
    fd0 = fd_cnt;
    host_start(T_HOST);
    capture("t5a", e1, -1, 20);
    repeat (20) @(negedge clk);
    nRST = 1'b1;
    oe0 = oe_rise;
    repeat (300) @(negedge clk);
    check("t5.no_resume", 64'(oe_rise - oe0), 64'd0);
    check("t5.no_frame_done", 64'(fd_cnt - fd0), 64'd0);
    set_rand();
    host_start(T_HOST);
    capture("t5b", model_frame(hi, hd, ti, td), -1, -1);

    // Back-to-back starts with new bytes each time.
    fd0 = fd_cnt;
    set_rand();
    host_start(T_HOST);
    capture("t6a", model_frame(hi, hd, ti, td), -1, -1);
    repeat (1000) @(negedge clk);
    set_rand();
    host_start(T_HOST);
    capture("t6b", model_frame(hi, hd, ti, td), -1, -1);
    check("t6.two_frames", 64'(fd_cnt - fd0), 64'd2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
